// File: rtl/pipe_pkg.sv
// Shared control-word layout and stage-update encoding for the
// segmented processor's control pipeline.
package pipe_pkg;

   localparam int CTRL_W_DEF  = 10;

   localparam int SALTOINCOND = 9;
   localparam int REGDEST     = 8;
   localparam int FUENTEALU   = 7;
   localparam int MEMAREG     = 6;
   localparam int ESCRREG     = 5;
   localparam int LEERMEM     = 4;
   localparam int SALTOCOND   = 2;
   localparam int ALUOP_HI    = 1;
   localparam int ALUOP_LO    = 0;

   localparam logic [CTRL_W_DEF-1:0] BUBBLE = '0;

   typedef enum logic [1:0] {
      UPD_ADVANCE = 2'd0,
      UPD_HOLD    = 2'd1,
      UPD_BUBBLE  = 2'd2
   } upd_e;

   // Flush beats hold; a frozen upstream stage must feed a bubble, not a copy.
   function automatic upd_e stage_sel(input logic flush, input logic hold,
                                      input logic up_hold);
      if (flush)        return UPD_BUBBLE;
      else if (hold)    return UPD_HOLD;
      else if (up_hold) return UPD_BUBBLE;
      else              return UPD_ADVANCE;
   endfunction

endpackage

// File: rtl/ctrl_stage.sv
// One control-word pipeline register with flush, hold and bubble insertion.
module ctrl_stage
   import pipe_pkg::*;
#(
   parameter int CTRL_W = CTRL_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              hold,
   input  logic              up_hold,
   input  logic [CTRL_W-1:0] up_ctrl,
   input  logic              up_vld,
   output logic [CTRL_W-1:0] ctrl_q,
   output logic              vld_q,
   output logic              vld_d
);

   logic [CTRL_W-1:0] ctrl_d;
   upd_e              sel;

   always_comb begin
      sel    = stage_sel(flush, hold, up_hold);
      ctrl_d = ctrl_q;
      vld_d  = vld_q;
      unique case (sel)
         UPD_ADVANCE: begin
            ctrl_d = up_ctrl;
            vld_d  = up_vld;
         end
         UPD_BUBBLE: begin
            ctrl_d = '0;
            vld_d  = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         ctrl_q <= ctrl_d;
         vld_q  <= vld_d;
      end
   end

endmodule

// File: rtl/ctrl_pipe.sv
// Parametrised control-word pipeline from ID to write-back, with per-stage
// stall/flush, gated write-back controls and a saturating bubble counter.
module ctrl_pipe
   import pipe_pkg::*;
#(
   parameter int CTRL_W      = CTRL_W_DEF,
   parameter int STAGES      = 3,
   parameter int MEMAREG_BIT = MEMAREG,
   parameter int ESCRREG_BIT = ESCRREG,
   parameter int CNT_W       = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [CTRL_W-1:0]        Control,
   input  logic                     valid_in,
   input  logic [STAGES-1:0]        stall,
   input  logic [STAGES-1:0]        flush,
   output logic [STAGES*CTRL_W-1:0] stage_ctrl,
   output logic [STAGES-1:0]        stage_valid,
   output logic                     MemaReg,
   output logic                     EscrReg,
   output logic [CNT_W-1:0]         bubble_cnt,
   input  logic                     clr_cnt
);

   logic [STAGES-1:0][CTRL_W-1:0] ctrl_q;
   logic [STAGES-1:0]             vld_q;
   logic [STAGES-1:0]             vld_nxt;
   logic [STAGES-1:0]             hold;
   logic [CNT_W-1:0]              cnt_d, cnt_q;
   logic                          unused_vld_nxt;

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      // A stall downstream freezes this stage too.
      assign hold[g] = |stall[STAGES-1:g];

      if (g == 0) begin : g_first
         ctrl_stage #(.CTRL_W(CTRL_W)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush[g]),
            .hold    (hold[g]),
            .up_hold (1'b0),
            .up_ctrl (Control),
            .up_vld  (valid_in),
            .ctrl_q  (ctrl_q[g]),
            .vld_q   (vld_q[g]),
            .vld_d   (vld_nxt[g])
         );
      end else begin : g_rest
         ctrl_stage #(.CTRL_W(CTRL_W)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush[g]),
            .hold    (hold[g]),
            .up_hold (hold[g-1]),
            .up_ctrl (ctrl_q[g-1]),
            .up_vld  (vld_q[g-1]),
            .ctrl_q  (ctrl_q[g]),
            .vld_q   (vld_q[g]),
            .vld_d   (vld_nxt[g])
         );
      end
   end

   // Only the final stage's next-valid feeds the counter.
   assign unused_vld_nxt = ^vld_nxt;

   assign stage_ctrl  = ctrl_q;
   assign stage_valid = vld_q;
   assign MemaReg     = vld_q[STAGES-1] & ctrl_q[STAGES-1][MEMAREG_BIT];
   assign EscrReg     = vld_q[STAGES-1] & ctrl_q[STAGES-1][ESCRREG_BIT];

   always_comb begin
      cnt_d = cnt_q;
      if (clr_cnt)
         cnt_d = '0;
      else if (!vld_nxt[STAGES-1] && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus random traffic
// against an array-based model; a second instance has a 4-bit bubble counter.
module tb_ctrl_pipe;

   localparam int STG = 3;
   localparam int CW  = 10;
   localparam int VW  = 2 * (STG*CW + STG + 2) + 16 + 4;

   logic              clk = 1'b0;
   logic              reset, valid_in, clr_cnt;
   logic [CW-1:0]     Control;
   logic [STG-1:0]    stall, flush;
   logic [STG*CW-1:0] stage_ctrl, s_stage_ctrl;
   logic [STG-1:0]    stage_valid, s_stage_valid;
   logic              MemaReg, EscrReg, s_mema, s_escr;
   logic [15:0]       bubble_cnt;
   logic [3:0]        s_cnt;

   int checks = 0;
   int errors = 0;

   logic [CW-1:0] m_ctrl [STG];
   logic          m_vld  [STG];
   int unsigned   m_cnt16, m_cnt4;

   always #5 clk = ~clk;

   ctrl_pipe #(.CTRL_W(CW), .STAGES(STG), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .Control(Control), .valid_in(valid_in),
      .stall(stall), .flush(flush), .stage_ctrl(stage_ctrl),
      .stage_valid(stage_valid), .MemaReg(MemaReg), .EscrReg(EscrReg),
      .bubble_cnt(bubble_cnt), .clr_cnt(clr_cnt)
   );

   ctrl_pipe #(.CTRL_W(CW), .STAGES(STG), .CNT_W(4)) dut_s (
      .clk(clk), .reset(reset), .Control(Control), .valid_in(valid_in),
      .stall(stall), .flush(flush), .stage_ctrl(s_stage_ctrl),
      .stage_valid(s_stage_valid), .MemaReg(s_mema), .EscrReg(s_escr),
      .bubble_cnt(s_cnt), .clr_cnt(clr_cnt)
   );

   // Reference: apply the pipeline rules to whole-stage arrays each cycle.
   task automatic model_step();
      logic [CW-1:0] nc [STG];
      logic          nv [STG];
      if (reset) begin
         for (int i = 0; i < STG; i++) begin m_ctrl[i] = '0; m_vld[i] = 1'b0; end
         m_cnt16 = 0; m_cnt4 = 0;
         return;
      end
      for (int i = 0; i < STG; i++) begin
         if (flush[i]) begin
            nc[i] = '0; nv[i] = 1'b0;
         end else if ((stall >> i) != 0) begin
            nc[i] = m_ctrl[i]; nv[i] = m_vld[i];
         end else if (i > 0 && (stall >> (i-1)) != 0) begin
            nc[i] = '0; nv[i] = 1'b0;
         end else if (i == 0) begin
            nc[i] = Control; nv[i] = valid_in;
         end else begin
            nc[i] = m_ctrl[i-1]; nv[i] = m_vld[i-1];
         end
      end
      for (int i = 0; i < STG; i++) begin m_ctrl[i] = nc[i]; m_vld[i] = nv[i]; end
      if (clr_cnt) begin
         m_cnt16 = 0; m_cnt4 = 0;
      end else if (!nv[STG-1]) begin
         if (m_cnt16 < 65535) m_cnt16++;
         if (m_cnt4 < 15) m_cnt4++;
      end
   endtask

   function automatic logic [VW-1:0] exp_vec();
      logic [STG*CW-1:0] fc;
      logic [STG-1:0]    fv;
      logic              me, ee;
      for (int i = 0; i < STG; i++) begin
         fc[i*CW +: CW] = m_ctrl[i];
         fv[i]          = m_vld[i];
      end
      me = m_vld[STG-1] & m_ctrl[STG-1][6];
      ee = m_vld[STG-1] & m_ctrl[STG-1][5];
      return {fc, fv, me, ee, 16'(m_cnt16), fc, fv, me, ee, 4'(m_cnt4)};
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {stage_ctrl, stage_valid, MemaReg, EscrReg, bubble_cnt,
              s_stage_ctrl, s_stage_valid, s_mema, s_escr, s_cnt};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      reset = 1'b0; valid_in = 1'b0; Control = '0;
      stall = '0; flush = '0; clr_cnt = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      tick(); tick();
      checks++;
      if (stage_valid !== 3'b000 || stage_ctrl !== '0 || bubble_cnt !== 16'd0 ||
          MemaReg !== 1'b0 || EscrReg !== 1'b0 || s_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset: valid=%b ctrl=%h cnt=%0d mema=%b escr=%b scnt=%0d, want all zero",
                  stage_valid, stage_ctrl, bubble_cnt, MemaReg, EscrReg, s_cnt);
      end
      reset = 1'b0;
   endtask

   task automatic test_stream();
      logic [2:0]  exp_v [4];
      logic        exp_w [4];
      logic [15:0] exp_c [4];
      exp_v = '{3'b001, 3'b010, 3'b100, 3'b000};
      exp_w = '{1'b0, 1'b0, 1'b1, 1'b0};
      exp_c = '{16'd1, 16'd2, 16'd2, 16'd3};
      Control = 10'h060; valid_in = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         Control = '0; valid_in = 1'b0;
         checks++;
         if (stage_valid !== exp_v[c] || MemaReg !== exp_w[c] || EscrReg !== exp_w[c] ||
             bubble_cnt !== exp_c[c]) begin
            errors++;
            $display("FAIL stream c%0d: valid=%b mema=%b escr=%b cnt=%0d, want %b %b %b %0d",
                     c, stage_valid, MemaReg, EscrReg, bubble_cnt, exp_v[c], exp_w[c], exp_w[c], exp_c[c]);
         end
      end
   endtask

   task automatic test_stall_mid();
      logic [CW-1:0] s0, s1;
      Control = 10'h020; valid_in = 1'b1; tick();
      Control = 10'h040; tick();
      Control = '0; valid_in = 1'b0; stall = 3'b010;
      for (int c = 0; c < 2; c++) begin
         tick();
         s0 = stage_ctrl[CW-1:0]; s1 = stage_ctrl[2*CW-1:CW];
         checks++;
         if (s0 !== 10'h040 || s1 !== 10'h020 || stage_valid !== 3'b011 || EscrReg !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold c%0d: s0=%h s1=%h valid=%b escr=%b, want 040 020 011 0",
                     c, s0, s1, stage_valid, EscrReg);
         end
      end
      stall = '0;
      tick();
      checks++;
      if (EscrReg !== 1'b1 || MemaReg !== 1'b0 || stage_ctrl[3*CW-1:2*CW] !== 10'h020) begin
         errors++;
         $display("FAIL stall_a_wb: escr=%b mema=%b s2=%h, want 1 0 020",
                  EscrReg, MemaReg, stage_ctrl[3*CW-1:2*CW]);
      end
      tick();
      checks++;
      if (MemaReg !== 1'b1 || EscrReg !== 1'b0 || stage_ctrl[3*CW-1:2*CW] !== 10'h040) begin
         errors++;
         $display("FAIL stall_b_wb: mema=%b escr=%b s2=%h, want 1 0 040",
                  MemaReg, EscrReg, stage_ctrl[3*CW-1:2*CW]);
      end
   endtask

   task automatic test_flush();
      // A sits in stage 0 and would enter stage 1 at the flush edge.
      Control = 10'h020; valid_in = 1'b1; tick();
      Control = 10'h060; flush = 3'b011; tick();
      Control = '0; valid_in = 1'b0; flush = '0;
      checks++;
      if (stage_valid[1:0] !== 2'b00 || stage_ctrl[2*CW-1:0] !== '0) begin
         errors++;
         $display("FAIL flush: valid=%b ctrl=%h, want low stages 0", stage_valid, stage_ctrl);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (EscrReg !== 1'b0) begin
            errors++;
            $display("FAIL flush_escr c%0d: escr=%b, want 0", c, EscrReg);
         end
      end
   endtask

   task automatic test_stall_flush();
      Control = 10'h060; valid_in = 1'b1; tick();
      Control = 10'h020; tick();
      Control = 10'h040; stall = 3'b010; flush = 3'b010; tick();
      checks++;
      if (stage_valid !== 3'b001 || stage_ctrl[CW-1:0] !== 10'h020 ||
          stage_ctrl[3*CW-1:CW] !== '0) begin
         errors++;
         $display("FAIL stall_flush: valid=%b ctrl=%h, want 001 s0=020", stage_valid, stage_ctrl);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      Control = 10'h060; valid_in = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (stage_valid !== 3'b111 || MemaReg !== 1'b1) begin
         errors++;
         $display("FAIL fill: valid=%b mema=%b, want 111 1", stage_valid, MemaReg);
      end
      reset = 1'b1; tick();
      reset = 1'b0; valid_in = 1'b0; Control = '0;
      checks++;
      if (stage_valid !== 3'b000 || stage_ctrl !== '0 || MemaReg !== 1'b0 ||
          EscrReg !== 1'b0 || bubble_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_mid: valid=%b ctrl=%h mema=%b escr=%b cnt=%0d, want all zero",
                  stage_valid, stage_ctrl, MemaReg, EscrReg, bubble_cnt);
      end
   endtask

   task automatic test_saturation();
      idle_inputs();
      clr_cnt = 1'b1; tick();
      clr_cnt = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL sat_idle c%0d: got %h want %h", c, dut_vec(), exp_vec());
         end
      end
      checks++;
      if (s_cnt !== 4'd15 || bubble_cnt !== 16'd20) begin
         errors++;
         $display("FAIL sat_top: scnt=%0d cnt=%0d, want 15 20", s_cnt, bubble_cnt);
      end
      clr_cnt = 1'b1; tick();
      checks++;
      if (s_cnt !== 4'd0 || bubble_cnt !== 16'd0) begin
         errors++;
         $display("FAIL sat_clr: scnt=%0d cnt=%0d, want 0 0", s_cnt, bubble_cnt);
      end
      clr_cnt = 1'b0; tick();
      checks++;
      if (s_cnt !== 4'd1 || bubble_cnt !== 16'd1) begin
         errors++;
         $display("FAIL sat_after_clr: scnt=%0d cnt=%0d, want 1 1", s_cnt, bubble_cnt);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         Control  = CW'($urandom);
         valid_in = 1'($urandom);
         stall    = ($urandom_range(0, 3) == 0) ? STG'($urandom) : '0;
         flush    = ($urandom_range(0, 5) == 0) ? STG'($urandom) : '0;
         clr_cnt  = ($urandom_range(0, 19) == 0);
         reset    = ($urandom_range(0, 59) == 0);
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random c%0d: got %h want %h", c, dut_vec(), exp_vec());
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_stream();
      test_stall_mid();
      test_flush();
      test_stall_flush();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
